dds_phase2amp: RTL
==================

// Module: dds_phase2amp
// PURPOSE
//  Downstream neighbour of the DDS phase accumulator. Converts the 32-bit accumulated phase,
//  plus the 11-bit phase offset, into an unsigned offset-binary DAC sample.
//  Supports four waveforms: sine (quarter-wave ROM), square, triangle and sawtooth.
//  Four-stage pipeline with a valid flag, so the accumulator can run every cycle or be gated.
// PARAMETERS
//  DW       10   output amplitude width; legal 8..10; ROM magnitude width is DW-1
//  PW       11   truncated phase width; fixed to match the 11-bit phase offset
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    synchronous, active-high reset
//  phase_acc  in   32   accumulated phase; only bits [31:21] are used
//  phase_off  in   11   phase offset P, added modulo 2^11
//  wave_sel   in   2    0 = sine, 1 = square, 2 = triangle, 3 = sawtooth
//  in_valid   in   1    sample strobe for phase_acc, phase_off and wave_sel
//  amp        out  DW   amplitude, offset binary; mid-scale is 2^(DW-1)
//  out_valid  out  1    amp holds a new sample this cycle
// BEHAVIOUR
//  - Reset: every pipeline register clears to 0; amp = 2^(DW-1) (512 at DW=10); out_valid = 0.
//    Reset mid-stream discards all in-flight samples, with no partial output.
//  - Latency: a sample taken on clock edge n appears on amp/out_valid after edge n+4.
//    Throughput is one sample per clock. wave_sel and phase_off travel with their own sample.
//  - S1: ph = phase_acc[31:21] + phase_off, 11-bit, carry discarded.
//    Example: ph 0x7FF + off 1 -> 0x000.
//  - S2: q = ph[10:9], idx = ph[8:0].
//    addr = q[0] ? ~idx : idx (mirror). neg = q[1]. Register addr, neg, ph and sel.
//  - S3: ROM read is registered: m = ROM[addr].
//    ROM[a] = round((2^(DW-1)-1) * sin(pi/2 * (a+0.5)/512)), a = 0..511.
//    The half-LSB offset makes the mirroring exact.
//  - S4: output mux, registered.
//    sine:     neg ? (2^(DW-1)-1 - m) : (2^(DW-1) + m)
//    square:   ph[10] ? 0 : 2^DW-1
//    triangle: top DW bits of ({ph[9:0]} ^ {10{ph[10]}})
//    sawtooth: ph[10 -: DW]
//  - in_valid low inserts a bubble. The valid bit shifts down the pipeline.
//    When out_valid = 0, amp holds its last value; it never glitches on a bubble.
//  - No backpressure: downstream must accept every out_valid cycle.
// STRUCTURE
//  - Shared package dds_pkg: DDS_PW = 11, DDS_QW_AW = 9, and WAVE_SINE/SQUARE/TRI/SAW (2-bit).
//  - Sub-module dds_qsin_rom: 512 x (DW-1) quarter-sine table with a registered output.
//    Filled from a generated case table or by $readmemh of qsin_<DW>.hex.
//  - The top level holds the S1/S2/S4 registers, the valid shift chain and the output mux.
// TESTING  (DW = 10; amp is checked exactly 4 cycles after the stimulus edge)
//  1. Sine, off = 0, acc 0x0000_0000 / 0x4000_0000 / 0x8000_0000 / 0xC000_0000 back-to-back
//     -> amp = 513, 1023, 510, 0 on consecutive cycles.
//  2. Offset wrap: acc 0xFFE0_0000, off 1, sine -> same amp as phase 0 (513).
//     Also off 0x200 with acc 0 -> 1023.
//  3. Square at ph 0x3FF -> 1023 and at ph 0x400 -> 0. Sawtooth at ph 0x400 -> 512.
//     Triangle at ph 0x200 -> 512 and at ph 0x600 -> 511.
//  4. in_valid pattern 1,0,0,1 -> out_valid = 1,0,0,1 delayed by 4 cycles.
//     amp holds across the bubbles.
//  5. wave_sel changes every cycle with a constant phase -> each output uses its own sample's
//     wave_sel, with no cross-talk between samples.
//  6. rst asserted with 3 samples in flight -> next cycle amp = 512 and out_valid = 0.
//     No stale sample appears after rst is released.
//  7. Sweep all 2048 phases in sine mode -> matches the real-valued model within 1 LSB.
//     The output is odd-symmetric about mid-scale.

Source files
------------

// File: rtl/dds_phase2amp_pkg.sv
// Shared DDS definitions: phase/ROM widths, waveform codes and the quarter-sine
// table generator used at elaboration time.
package dds_pkg;
  localparam int DDS_PW    = 11;
  localparam int DDS_QW_AW = 9;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  // round((2^mw - 1) * sin(pi/2 * (a+0.5)/512)); Taylor series keeps it tool-neutral
  function automatic int qsin_val(input int a, input int mw);
    real x, x2, term, s, full;
    x    = 3.14159265358979323846 * (real'(a) + 0.5) / 1024.0;
    x2   = x * x;
    term = x;
    s    = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x2 / real'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    full = real'((1 << mw) - 1);
    return int'(full * s);
  endfunction
endpackage

// File: rtl/dds_phase2amp_if.sv
// Sample bus between the phase accumulator and the phase-to-amplitude converter.
interface dds_phase2amp_if import dds_pkg::*; #(parameter int DW = 10);
  logic [31:0]       phase_acc;
  logic [DDS_PW-1:0] phase_off;
  logic [1:0]        wave_sel;
  logic              in_valid;
  logic [DW-1:0]     amp;
  logic              out_valid;

  modport master (output phase_acc, phase_off, wave_sel, in_valid,
                  input  amp, out_valid);
  modport slave  (input  phase_acc, phase_off, wave_sel, in_valid,
                  output amp, out_valid);
endinterface

// File: rtl/dds_qsin_rom.sv
// 512 x (DW-1) quarter-sine magnitude table with a registered read port.
module dds_qsin_rom import dds_pkg::*; #(
  parameter int DW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DDS_QW_AW-1:0] addr,
  output logic [DW-2:0]        mag
);
  localparam int DEPTH = 1 << DDS_QW_AW;

  logic [DW-2:0] tbl [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    localparam logic [DW-2:0] V = (DW-1)'(qsin_val(i, DW - 1));
    assign tbl[i] = V;
  end

  always_ff @(posedge clk) begin
    if (rst) mag <= '0;
    else     mag <= tbl[addr];
  end
endmodule

// File: rtl/dds_phase2amp.sv
// Phase-to-amplitude converter: offset add, quadrant fold, quarter-sine ROM and
// waveform mux in a four-register pipeline with a travelling valid bit.
module dds_phase2amp import dds_pkg::*; #(
  parameter int DW = 10,
  parameter int PW = DDS_PW
) (
  input logic            clk,
  input logic            rst,
  dds_phase2amp_if.slave bus
);
  localparam int            STAGES = 3;
  localparam logic [DW-1:0] MID    = DW'(1) << (DW - 1);

  logic [STAGES:0] vld_pipe;

  logic [PW-1:0]        s1_ph;
  wave_e                s1_sel;
  logic [PW-1:0]        s2_ph;
  wave_e                s2_sel;
  logic                 s2_neg;
  logic [DDS_QW_AW-1:0] s2_addr;
  logic [PW-1:0]        s3_ph;
  wave_e                s3_sel;
  logic                 s3_neg;
  logic [DW-2:0]        s3_mag;
  logic [PW-2:0]        s3_tri;
  logic [DW-1:0]        amp_nxt;
  logic [DW-1:0]        amp_r;

  logic unused_acc_lsb;
  assign unused_acc_lsb = ^bus.phase_acc[31-PW:0];

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
  end

  // Data registers free-run; only the output register is qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ph   <= '0;
      s1_sel  <= WAVE_SINE;
      s2_ph   <= '0;
      s2_sel  <= WAVE_SINE;
      s2_neg  <= 1'b0;
      s2_addr <= '0;
      s3_ph   <= '0;
      s3_sel  <= WAVE_SINE;
      s3_neg  <= 1'b0;
    end else begin
      s1_ph   <= bus.phase_acc[31 -: PW] + bus.phase_off;
      s1_sel  <= wave_e'(bus.wave_sel);
      s2_ph   <= s1_ph;
      s2_sel  <= s1_sel;
      s2_neg  <= s1_ph[PW-1];
      s2_addr <= s1_ph[PW-2] ? ~s1_ph[DDS_QW_AW-1:0] : s1_ph[DDS_QW_AW-1:0];
      s3_ph   <= s2_ph;
      s3_sel  <= s2_sel;
      s3_neg  <= s2_neg;
    end
  end

  dds_qsin_rom #(.DW(DW)) u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (s2_addr),
    .mag  (s3_mag)
  );

  assign s3_tri = s3_ph[PW-2:0] ^ {(PW-1){s3_ph[PW-1]}};

  // Sine halves: MID-1-m is ~m with a 0 MSB, MID+m is m with a 1 MSB.
  always_comb begin
    amp_nxt = amp_r;
    case (s3_sel)
      WAVE_SINE:   amp_nxt = s3_neg ? {1'b0, ~s3_mag} : {1'b1, s3_mag};
      WAVE_SQUARE: amp_nxt = {DW{~s3_ph[PW-1]}};
      WAVE_TRI:    amp_nxt = s3_tri[PW-2 -: DW];
      WAVE_SAW:    amp_nxt = s3_ph[PW-1 -: DW];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)               amp_r <= MID;
    else if (vld_pipe[2])  amp_r <= amp_nxt;
  end

  assign bus.amp       = amp_r;
  assign bus.out_valid = vld_pipe[STAGES];
endmodule
